// File: rtl/icon_sched.sv
// ---------------------------------------------------------------------------
// icon_sched -- two-lane issue scheduler in front of an interconnect switch node.
//
// Each lane owns a single hold register. A request is accepted when the lane
// is empty, or when the entry it currently holds is being issued in the same
// cycle. Held entries are issued on their own lane, one cycle after they are
// granted. The downstream switch node steers on address bit STAGE. Two held
// entries that would take the same switch output are in conflict. A 1-bit
// round-robin pointer then decides which lane goes first, and the other lane
// waits one cycle. The switch node applies no backpressure, so an issued
// entry is final.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid_n/addr_n/data_n  request from lane n (n = 0, 1)
//   o_req_ready_n                lane n accepts when high together with valid
//   o_valid_n/addr_n/data_n      registered issue toward the switch node
//   i_clr_cnt                    clear the conflict counter (beats increment)
//   o_conflict_cnt               saturating count of conflict cycles
// ---------------------------------------------------------------------------
module icon_sched #(
   parameter int DATA_W = 1,
   parameter int ADDR_W = 9,
   parameter int STAGE  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid_0,
   input  logic [ADDR_W-1:0] i_req_addr_0,
   input  logic [DATA_W-1:0] i_req_data_0,
   output logic              o_req_ready_0,
   input  logic              i_req_valid_1,
   input  logic [ADDR_W-1:0] i_req_addr_1,
   input  logic [DATA_W-1:0] i_req_data_1,
   output logic              o_req_ready_1,
   output logic              o_valid_0,
   output logic [ADDR_W-1:0] o_addr_0,
   output logic [DATA_W-1:0] o_data_0,
   output logic              o_valid_1,
   output logic [ADDR_W-1:0] o_addr_1,
   output logic [DATA_W-1:0] o_data_1,
   input  logic              i_clr_cnt,
   output logic [CNT_W-1:0]  o_conflict_cnt
);

   typedef enum logic {
      LANE_EMPTY = 1'b0,
      LANE_FULL  = 1'b1
   } lane_state_t;

   // Lane-indexed views of the flat port list.
   logic [1:0]        w_req_valid;
   logic [ADDR_W-1:0] w_req_addr [2];
   logic [DATA_W-1:0] w_req_data [2];
   logic [1:0]        w_ready;
   logic [1:0]        w_hold_v;
   logic [1:0]        w_hold_sel;   // held address bit STAGE, per lane
   logic [1:0]        w_grant;
   logic              w_conflict;
   logic [1:0]        w_issue_v;
   logic [ADDR_W-1:0] w_issue_addr [2];
   logic [DATA_W-1:0] w_issue_data [2];

   logic              r_rr;
   logic [CNT_W-1:0]  r_conflict_cnt;

   assign w_req_valid   = {i_req_valid_1, i_req_valid_0};
   assign w_req_addr[0] = i_req_addr_0;
   assign w_req_addr[1] = i_req_addr_1;
   assign w_req_data[0] = i_req_data_0;
   assign w_req_data[1] = i_req_data_1;

   // --------------------------------------------------------------------
   // Arbitration. By default every held entry is granted. That already
   // covers the "both, no conflict", "only one" and "none" cases. A conflict
   // narrows the grant to the round-robin lane.
   // --------------------------------------------------------------------
   always_comb begin
      w_conflict = w_hold_v[0] & w_hold_v[1] & (w_hold_sel[0] == w_hold_sel[1]);
      w_grant    = w_hold_v;
      if (w_conflict) begin
         w_grant = r_rr ? 2'b10 : 2'b01;
      end
   end

   // Reset forces ready high so that upstream sees empty lanes. The lane
   // registers ignore any handshake in that cycle because reset wins.
   assign w_ready = ~w_hold_v | w_grant | {2{i_rst}};

   // The pointer advances only after it has served a conflict, so that the
   // other lane is favoured at the next conflict.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr <= 1'b0;
      end else if (w_conflict) begin
         r_rr <= ~r_rr;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr_cnt) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
         r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
   end

   // --------------------------------------------------------------------
   // Per-lane hold FSM and issue register.
   // --------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_state_t       r_state;
      lane_state_t       w_state_next;
      logic              w_load;
      logic [ADDR_W-1:0] r_hold_addr;
      logic [DATA_W-1:0] r_hold_data;
      logic              r_issue_v;
      logic [ADDR_W-1:0] r_issue_addr;
      logic [DATA_W-1:0] r_issue_data;

      always_comb begin
         w_state_next = r_state;
         w_load       = 1'b0;
         case (r_state)
            LANE_EMPTY: begin
               if (w_req_valid[gi]) begin
                  w_state_next = LANE_FULL;
                  w_load       = 1'b1;
               end
            end
            LANE_FULL: begin
               // Refill in the same cycle the current entry leaves.
               if (w_grant[gi] && w_req_valid[gi]) begin
                  w_load = 1'b1;
               end else if (w_grant[gi]) begin
                  w_state_next = LANE_EMPTY;
               end
            end
         endcase
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_state <= LANE_EMPTY;
         end else begin
            r_state <= w_state_next;
         end
      end

      // The payload needs no reset because it is qualified by r_state.
      always_ff @(posedge i_clk) begin
         if (w_load) begin
            r_hold_addr <= w_req_addr[gi];
            r_hold_data <= w_req_data[gi];
         end
      end

      // Issue fields keep their last value when nothing is granted.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_issue_v    <= 1'b0;
            r_issue_addr <= '0;
            r_issue_data <= '0;
         end else begin
            r_issue_v <= w_grant[gi];
            if (w_grant[gi]) begin
               r_issue_addr <= r_hold_addr;
               r_issue_data <= r_hold_data;
            end
         end
      end

      assign w_hold_v[gi]     = (r_state == LANE_FULL);
      assign w_hold_sel[gi]   = r_hold_addr[STAGE];
      assign w_issue_v[gi]    = r_issue_v;
      assign w_issue_addr[gi] = r_issue_addr;
      assign w_issue_data[gi] = r_issue_data;
   end

   assign o_req_ready_0  = w_ready[0];
   assign o_req_ready_1  = w_ready[1];
   assign o_valid_0      = w_issue_v[0];
   assign o_addr_0       = w_issue_addr[0];
   assign o_data_0       = w_issue_data[0];
   assign o_valid_1      = w_issue_v[1];
   assign o_addr_1       = w_issue_addr[1];
   assign o_data_1       = w_issue_data[1];
   assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_icon_sched.sv
// ---------------------------------------------------------------------------
// tb_icon_sched -- directed bench for icon_sched (DATA_W=8, ADDR_W=9,
// STAGE=8, CNT_W=2). Inputs change 1 time unit after the rising edge, and
// outputs are sampled on the falling edge. "Cycle 0" is the cycle in which a
// handshake is presented.
// ---------------------------------------------------------------------------
module tb_icon_sched;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 9;
   localparam int STAGE  = 8;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              v0, v1, r0, r1, clr;
   logic [ADDR_W-1:0] a0, a1, oa0, oa1;
   logic [DATA_W-1:0] d0, d1, od0, od1;
   logic              ov0, ov1;
   logic [CNT_W-1:0]  cnt;

   int n_checks = 0;
   int n_pass   = 0;

   icon_sched #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGE(STAGE), .CNT_W(CNT_W)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid_0 (v0),
      .i_req_addr_0  (a0),
      .i_req_data_0  (d0),
      .o_req_ready_0 (r0),
      .i_req_valid_1 (v1),
      .i_req_addr_1  (a1),
      .i_req_data_1  (d1),
      .o_req_ready_1 (r1),
      .o_valid_0     (ov0),
      .o_addr_0      (oa0),
      .o_data_0      (od0),
      .o_valid_1     (ov1),
      .o_addr_1      (oa1),
      .o_data_1      (od1),
      .i_clr_cnt     (clr),
      .o_conflict_cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("[%0t] ok   %s = 0x%0h", $time, tag, got);
      end else begin
         $display("[%0t] FAIL %s: got 0x%0h, expected 0x%0h", $time, tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] idx0, idx1, got0, got1;
   logic       hs0, hs1;

   initial begin
      rst = 1'b1; clr = 1'b0;
      v0 = 1'b0; a0 = '0; d0 = '0;
      v1 = 1'b0; a1 = '0; d1 = '0;

      // ---------------- power-up reset ----------------
      @(negedge clk);
      check("rst_rdy0", r0, 1);
      check("rst_rdy1", r1, 1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("idle_v0", ov0, 0);
      check("idle_v1", ov1, 0);
      check("idle_cnt", cnt, 0);
      check("idle_rdy0", r0, 1);
      check("idle_rdy1", r1, 1);

      // ---------------- no-conflict pair ----------------
      next_cycle();
      v0 = 1'b1; a0 = 9'h005; d0 = 8'hA0;
      v1 = 1'b1; a1 = 9'h105; d1 = 8'hB1;
      @(negedge clk);
      check("nc_rdy0", r0, 1);
      check("nc_rdy1", r1, 1);
      next_cycle();
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      check("nc_c1_v0", ov0, 0);
      check("nc_c1_v1", ov1, 0);
      next_cycle();
      @(negedge clk);
      check("nc_c2_v0", ov0, 1);
      check("nc_c2_v1", ov1, 1);
      check("nc_c2_a0", oa0, 9'h005);
      check("nc_c2_a1", oa1, 9'h105);
      check("nc_c2_d0", od0, 8'hA0);
      check("nc_c2_d1", od1, 8'hB1);
      check("nc_c2_cnt", cnt, 0);
      next_cycle();
      @(negedge clk);
      check("nc_c3_v0", ov0, 0);
      check("nc_c3_v1", ov1, 0);

      // ---------------- conflict with round-robin ----------------
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      v0 = 1'b1; a0 = 9'h100; d0 = 8'h11;
      v1 = 1'b1; a1 = 9'h1AA; d1 = 8'h22;
      @(negedge clk);
      check("rr1_c0_rdy0", r0, 1);
      check("rr1_c0_rdy1", r1, 1);
      next_cycle();
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      check("rr1_c1_rdy0", r0, 1);
      check("rr1_c1_rdy1", r1, 0);
      next_cycle();
      @(negedge clk);
      check("rr1_c2_v0", ov0, 1);
      check("rr1_c2_v1", ov1, 0);
      check("rr1_c2_a0", oa0, 9'h100);
      check("rr1_c2_d0", od0, 8'h11);
      check("rr1_c2_cnt", cnt, 1);
      next_cycle();
      @(negedge clk);
      check("rr1_c3_v0", ov0, 0);
      check("rr1_c3_v1", ov1, 1);
      check("rr1_c3_a1", oa1, 9'h1AA);
      check("rr1_c3_d1", od1, 8'h22);
      check("rr1_c3_cnt", cnt, 1);

      // Repeat: the pointer now favours lane 1.
      next_cycle();
      v0 = 1'b1; a0 = 9'h180; d0 = 8'h33;
      v1 = 1'b1; a1 = 9'h1C0; d1 = 8'h44;
      @(negedge clk);
      next_cycle();
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      check("rr2_c1_rdy0", r0, 0);
      check("rr2_c1_rdy1", r1, 1);
      next_cycle();
      @(negedge clk);
      check("rr2_c2_v0", ov0, 0);
      check("rr2_c2_v1", ov1, 1);
      check("rr2_c2_a1", oa1, 9'h1C0);
      check("rr2_c2_cnt", cnt, 2);
      next_cycle();
      @(negedge clk);
      check("rr2_c3_v0", ov0, 1);
      check("rr2_c3_v1", ov1, 0);
      check("rr2_c3_a0", oa0, 9'h180);
      check("rr2_c3_d0", od0, 8'h33);
      check("rr2_c3_cnt", cnt, 2);

      // ---------------- counter clear ----------------
      next_cycle();
      clr = 1'b1;
      @(negedge clk);
      next_cycle();
      clr = 1'b0;
      @(negedge clk);
      check("clr_cnt", cnt, 0);

      // ---------------- conflicting streams, scoreboard, saturation ------
      idx0 = '0; idx1 = '0; got0 = '0; got1 = '0;
      hs0 = 1'b0; hs1 = 1'b0;
      for (int c = 0; c < 30; c++) begin
         next_cycle();
         if (hs0) idx0++;
         if (hs1) idx1++;
         v0 = (idx0 < 8'd6); a0 = {1'b1, idx0};         d0 = 8'h40 + idx0;
         v1 = (idx1 < 8'd6); a1 = {1'b1, 8'h80 + idx1}; d1 = 8'h80 + idx1;
         @(negedge clk);
         hs0 = v0 && r0;
         hs1 = v1 && r1;
         if (c >= 1 && c <= 9) check("st_rdy_alt", r0 ^ r1, 1);
         if (c == 3) check("st_cnt_c3", cnt, 2);
         if (c == 6) check("st_cnt_sat", cnt, 3);
         check("st_no_dual", ov0 && ov1, 0);
         if (ov0) begin
            check("st_data0", od0, 8'h40 + got0);
            got0++;
         end
         if (ov1) begin
            check("st_data1", od1, 8'h80 + got1);
            got1++;
         end
      end
      v0 = 1'b0; v1 = 1'b0;
      check("st_count0", got0, 6);
      check("st_count1", got1, 6);
      check("st_cnt_end", cnt, 3);

      // ---------------- clear concurrent with a conflict ----------------
      next_cycle();
      v0 = 1'b1; a0 = 9'h1F0; d0 = 8'h55;
      v1 = 1'b1; a1 = 9'h1F1; d1 = 8'h66;
      @(negedge clk);
      next_cycle();
      v0 = 1'b0; v1 = 1'b0; clr = 1'b1;
      @(negedge clk);
      check("cc_c1_cnt", cnt, 3);
      next_cycle();
      clr = 1'b0;
      @(negedge clk);
      check("cc_c2_cnt", cnt, 0);
      check("cc_c2_one", ov0 ^ ov1, 1);
      next_cycle();
      @(negedge clk);
      check("cc_c3_cnt", cnt, 0);
      check("cc_c3_one", ov0 ^ ov1, 1);
      next_cycle();
      @(negedge clk);
      check("cc_c4_none", ov0 | ov1, 0);

      // ---------------- reset mid-operation ----------------
      next_cycle();
      v0 = 1'b1; a0 = 9'h1A0; d0 = 8'h77;
      v1 = 1'b1; a1 = 9'h1B0; d1 = 8'h88;
      @(negedge clk);
      next_cycle();
      a0 = 9'h1A1; d0 = 8'h79;
      a1 = 9'h1B1; d1 = 8'h89;
      @(negedge clk);
      next_cycle();
      v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rm_pre_cnt", cnt, 1);
      check("rm_pre_one", ov0 ^ ov1, 1);
      check("rm_rst_rdy0", r0, 1);
      check("rm_rst_rdy1", r1, 1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rm_v0", ov0, 0);
      check("rm_v1", ov1, 0);
      check("rm_a0", oa0, 0);
      check("rm_a1", oa1, 0);
      check("rm_d0", od0, 0);
      check("rm_d1", od1, 0);
      check("rm_cnt", cnt, 0);
      check("rm_rdy0", r0, 1);
      check("rm_rdy1", r1, 1);
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         @(negedge clk);
         check("rm_no_stale", ov0 | ov1, 0);
      end

      // ---------------- single lane, back-to-back ----------------
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         v1 = (c < 4);
         a1 = 9'h1FF;
         d1 = 8'(c + 1);
         @(negedge clk);
         if (c < 4) check("sl_rdy1", r1, 1);
         check("sl_v0", ov0, 0);
         check("sl_v1", ov1, (c >= 2 && c <= 5));
         if (c >= 2 && c <= 5) begin
            check("sl_a1", oa1, 9'h1FF);
            check("sl_d1", od1, c - 1);
         end
         if (c == 6) check("sl_keep_d1", od1, 4);
      end
      v1 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icon_sched.md
ICON_SCHED -- requirements
Module: icon_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 1, payload width per lane.
REQ-002 SHALL have parameter ADDR_W, default 9, destination address width per lane.
REQ-003 SHALL have parameter STAGE, default 8, address bit index steering the downstream switch node.
REQ-004 SHALL have parameter CNT_W, default 16, conflict counter width.
REQ-005 SHALL have one clock and a synchronous active-high reset: i_clk input 1 clock; i_rst input 1 synchronous active-high reset.
REQ-006 SHALL have these request ports, n = 0, 1: i_req_valid_n input 1 request valid; i_req_addr_n input ADDR_W request address; i_req_data_n input DATA_W request data; o_req_ready_n output 1 request accepted when high with valid.
REQ-007 SHALL have these issue ports toward the switch node, n = 0, 1: o_valid_n output 1 lane valid; o_addr_n output ADDR_W lane address; o_data_n output DATA_W lane data.
REQ-008 SHALL have i_clr_cnt input 1, clear conflict counter.
REQ-009 SHALL have o_conflict_cnt output CNT_W, saturating conflict count.

Function
REQ-010 SHALL hold one entry per lane (hold_v_n, hold_addr_n, hold_data_n), each lane state EMPTY (hold_v_n=0) or FULL (hold_v_n=1).
REQ-011 SHALL assert o_req_ready_n = !hold_v_n || grant_n combinationally; handshake = valid && ready in the same cycle.
REQ-012 SHALL, on handshake on lane n, load the hold register on the next edge; hold_v_n then stays 1 (FULL->FULL), else grant_n clears it (FULL->EMPTY).
REQ-013 SHALL detect conflict = hold_v_0 && hold_v_1 && (hold_addr_0[STAGE] == hold_addr_1[STAGE]).
REQ-014 SHALL set grants: both held and no conflict -> grant_0 = grant_1 = 1; conflict -> grant only lane rr; exactly one held -> grant that lane; none held -> no grant.
REQ-015 SHALL keep a 1-bit round-robin pointer rr that toggles only on a conflict cycle, after serving lane rr; otherwise rr holds.
REQ-016 SHALL register issue outputs: on the next edge o_valid_n <= grant_n; on grant o_addr_n/o_data_n <= hold_addr_n/hold_data_n, otherwise they keep their last values.
REQ-017 SHALL keep each granted entry on its own lane (no lane swapping); routing is done by the switch node.
REQ-018 SHALL make latency 2 cycles from handshake to o_valid_n when uncontended; each conflict adds 1 cycle to the loser.
REQ-019 SHALL sustain 1 request per lane per cycle when consecutive pairs differ in bit STAGE.
REQ-020 SHALL increment the counter once per conflict cycle, saturating at 2^CNT_W-1 with no wrap.
REQ-021 SHALL clear the counter to 0 on i_clr_cnt, with clear taking priority over a same-cycle increment.
REQ-022 SHALL never drive o_valid_0 && o_valid_1 with equal o_addr_n[STAGE].
REQ-023 SHALL admit no backpressure from the switch node; issued entries are final.

Reset
REQ-024 SHALL, on i_rst high at a clock edge, clear hold_v_n, rr, o_valid_n, o_addr_n, o_data_n and o_conflict_cnt to 0.
REQ-025 SHALL, with i_rst high, drive o_req_ready_n = 1 (lanes EMPTY after the reset edge); handshakes in reset cycles are discarded.
REQ-026 SHALL, on reset mid-operation, drop held or in-flight entries without issuing them; the first post-reset request behaves as after power-up.

Verification
REQ-027 SHALL cover no-conflict pair: cycle 0 lane0 addr 0x005, lane1 addr 0x105 -> cycle 2 o_valid_0 = o_valid_1 = 1 with those addresses, counter 0.
REQ-028 SHALL cover conflict with round-robin: both lanes addr bit8 = 1 after reset -> lane0 issued cycle 2, lane1 cycle 3, counter 1, rr = 1; repeat -> lane1 first.
REQ-029 SHALL cover backpressure: lane0 continuous conflicting stream vs lane1 -> ready_n alternates, o_valid alternates 0/1 lanes, no entry lost or duplicated (scoreboard).
REQ-030 SHALL cover saturation: CNT_W = 2, 5 conflict cycles -> o_conflict_cnt = 3; i_clr_cnt concurrent with a conflict -> 0.
REQ-031 SHALL cover reset mid-operation: both lanes FULL in conflict, assert i_rst one cycle -> next cycle all outputs 0, ready = 1, no stale issue afterward.
REQ-032 SHALL cover single lane: only lane1 valid, addr 0x1FF, 4 back-to-back -> o_valid_1 high 4 consecutive cycles from cycle 2, o_valid_0 stays 0.
